// File: rtl/spi_input_conditioner.sv
// Front end of the SPI slave: synchronises the raw sclk/cs/mosi pins, debounces each
// channel over WAIT_TIME+1 stable cycles and emits one-cycle edge pulses.
module spi_input_conditioner #(
  parameter int WAIT_TIME     = 3,
  parameter int COUNTER_WIDTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_pos_edge,
  output logic sclk_neg_edge,
  output logic cs_cond,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_cond
);

  // Channel index 0 = sclk, 1 = cs, 2 = mosi; reset levels equal the idle bus state.
  localparam logic [2:0]               IDLE_LEVEL = 3'b010;
  localparam logic [COUNTER_WIDTH-1:0] WAIT_COUNT = COUNTER_WIDTH'(WAIT_TIME);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = COUNTER_WIDTH'(1);

  logic [2:0]                    pin_s;
  logic [2:0]                    sync0_r;
  logic [2:0]                    sync1_r;
  logic [2:0]                    cond_r;
  logic [2:0]                    cond_nxt_s;
  logic [2:0][COUNTER_WIDTH-1:0] count_r;
  logic [2:0][COUNTER_WIDTH-1:0] count_nxt_s;
  logic [1:0]                    rise_nxt_s;
  logic [1:0]                    fall_nxt_s;
  logic [1:0]                    rise_r;
  logic [1:0]                    fall_r;

  assign pin_s = {mosi_pin, cs_pin, sclk_pin};

  // Debounce decision: a level is accepted only after the counter has seen WAIT_TIME disagreeing cycles
  always_comb begin
    cond_nxt_s  = cond_r;
    count_nxt_s = count_r;
    for (int i = 0; i < 3; i++) begin
      if (sync1_r[i] == cond_r[i]) begin
        count_nxt_s[i] = COUNT_ZERO;
      end else if (count_r[i] != WAIT_COUNT) begin
        count_nxt_s[i] = count_r[i] + COUNT_ONE;
      end else begin
        cond_nxt_s[i]  = sync1_r[i];
        count_nxt_s[i] = COUNT_ZERO;
      end
    end
    rise_nxt_s = cond_nxt_s[1:0] & ~cond_r[1:0];
    fall_nxt_s = ~cond_nxt_s[1:0] & cond_r[1:0];
  end

  // Synchroniser, conditioned level, counters and registered edge pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_r <= IDLE_LEVEL;
      sync1_r <= IDLE_LEVEL;
      cond_r  <= IDLE_LEVEL;
      count_r <= {3{COUNT_ZERO}};
      rise_r  <= 2'b00;
      fall_r  <= 2'b00;
    end else begin
      sync0_r <= pin_s;
      sync1_r <= sync0_r;
      cond_r  <= cond_nxt_s;
      count_r <= count_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  assign sclk_pos_edge = rise_r[0];
  assign sclk_neg_edge = fall_r[0];
  assign cs_cond       = cond_r[1];
  assign cs_rise       = rise_r[1];
  assign cs_fall       = fall_r[1];
  assign mosi_cond     = cond_r[2];

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Self-checking bench for spi_input_conditioner: directed scenarios plus random pin
// activity, all compared against a sliding-window reference model.
module tb_spi_input_conditioner;

  localparam int W  = 3;
  localparam int HL = W + 3;

  logic clk = 1'b0;
  logic reset_n;
  logic sclk_pin, cs_pin, mosi_pin;
  logic sclk_pos_edge, sclk_neg_edge, cs_cond, cs_fall, cs_rise, mosi_cond;

  int checks = 0;
  int errors = 0;

  // Reference: a level is adopted once the last W+1 synchronised samples all differ from it
  bit m_hist [3][HL];
  bit m_cond [3];
  bit m_rise [3];
  bit m_fall [3];

  always #5 clk = ~clk;

  spi_input_conditioner #(.WAIT_TIME(W), .COUNTER_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .sclk_pos_edge(sclk_pos_edge), .sclk_neg_edge(sclk_neg_edge),
    .cs_cond(cs_cond), .cs_fall(cs_fall), .cs_rise(cs_rise), .mosi_cond(mosi_cond)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < HL; j++) m_hist[c][j] = (c == 1);
      m_cond[c] = (c == 1);
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit s, input bit c_in, input bit m);
    bit pins [3];
    bit acc;
    pins[0] = s; pins[1] = c_in; pins[2] = m;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < HL - 1; j++) m_hist[c][j] = m_hist[c][j+1];
      m_hist[c][HL-1] = pins[c];
      // Samples 0..W are the pin values that reached the second flop over the last W+1 edges
      acc = 1'b1;
      for (int j = 0; j <= W; j++) if (m_hist[c][j] == m_cond[c]) acc = 1'b0;
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (acc) begin
        m_cond[c] = m_hist[c][W];
        m_rise[c] = m_cond[c];
        m_fall[c] = !m_cond[c];
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("sclk_pos", sclk_pos_edge, m_rise[0]);
    check_eq("sclk_neg", sclk_neg_edge, m_fall[0]);
    check_eq("cs_cond",  cs_cond,       m_cond[1]);
    check_eq("cs_fall",  cs_fall,       m_fall[1]);
    check_eq("cs_rise",  cs_rise,       m_rise[1]);
    check_eq("mosi",     mosi_cond,     m_cond[2]);
  endtask

  // Called at a negedge; drives pins, advances one clk, checks, returns at the next negedge
  task automatic step(input bit s, input bit c_in, input bit m);
    sclk_pin = s; cs_pin = c_in; mosi_pin = m;
    @(posedge clk);
    if (reset_n) model_edge(s, c_in, m);
    else model_reset();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_pulses", {sclk_pos_edge, sclk_neg_edge, cs_fall, cs_rise}, 4'b0000);
  endtask

  initial begin
    int npos, nneg, nfall, nrise, found, found2, n;
    logic [7:0] bits;
    logic [7:0] byte_val;
    bit rs, rc, rm;
    int hs, hc, hm;

    reset_n = 1'b0; sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0;
    @(negedge clk);
    assert_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;

    // Idle pins: nothing happens
    npos = 0;
    repeat (20) begin
      step(1'b0, 1'b1, 1'b0);
      npos += int'(sclk_pos_edge);
    end
    check_eq("idle_pos", npos, 0);
    check_eq("idle_cs", cs_cond, 1);

    // cs falls: accepted on the sixth edge (edge 5), one pulse only
    found = 0; nfall = 0; npos = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (cs_fall && found == 0) found = i;
      nfall += int'(cs_fall);
      npos += int'(sclk_pos_edge) + int'(sclk_neg_edge) + int'(cs_rise);
    end
    check_eq("cs_fall_lat", found, 6);
    check_eq("cs_fall_cnt", nfall, 1);
    check_eq("cs_other", npos, 0);

    // Two-cycle sclk glitch is rejected, next genuine rise has full latency
    npos = 0;
    repeat (2) begin step(1'b1, 1'b0, 1'b0); npos += int'(sclk_pos_edge) + int'(sclk_neg_edge); end
    repeat (10) begin step(1'b0, 1'b0, 1'b0); npos += int'(sclk_pos_edge) + int'(sclk_neg_edge); end
    check_eq("glitch", npos, 0);
    found = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (sclk_pos_edge && found == 0) found = i;
    end
    check_eq("post_glitch_lat", found, 6);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Byte 0xA5, mosi changes on sclk fall, 8-cycle half periods
    byte_val = 8'hA5; bits = 8'h00; n = 0;
    for (int b = 7; b >= 0; b--) begin
      repeat (8) begin
        step(1'b0, 1'b0, byte_val[b]);
        if (sclk_pos_edge) begin bits = {bits[6:0], mosi_cond}; n++; end
      end
      repeat (8) begin
        step(1'b1, 1'b0, byte_val[b]);
        if (sclk_pos_edge) begin bits = {bits[6:0], mosi_cond}; n++; end
      end
    end
    repeat (8) begin
      step(1'b0, 1'b0, byte_val[0]);
      if (sclk_pos_edge) begin bits = {bits[6:0], mosi_cond}; n++; end
    end
    check_eq("byte_edges", n, 8);
    check_eq("byte_data", bits, 8'hA5);

    // sclk rise and cs rise at the pins in the same cycle
    found = 0; found2 = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (sclk_pos_edge && found == 0) found = i;
      if (cs_rise && found2 == 0) found2 = i;
    end
    check_eq("simul_pos", found, 6);
    check_eq("simul_rise", found2, 6);

    // Reset mid-byte with cs held low: instant reset, no pulses, cs_fall 5 edges after release
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    assert_reset();
    check_eq("rst_cs_cond", cs_cond, 1);
    npos = 0;
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0);
      npos += int'(sclk_pos_edge) + int'(sclk_neg_edge) + int'(cs_fall) + int'(cs_rise);
    end
    check_eq("rst_hold_pulses", npos, 0);
    reset_n = 1'b1;
    found = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (cs_fall && found == 0) found = i;
    end
    check_eq("rst_cs_fall_lat", found, 6);

    // Reset then release with idle pins: silence
    assert_reset();
    step(1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
    npos = 0;
    repeat (12) begin
      step(1'b0, 1'b1, 1'b0);
      npos += int'(sclk_pos_edge) + int'(sclk_neg_edge) + int'(cs_fall) + int'(cs_rise);
    end
    check_eq("idle_release", npos, 0);

    // Random activity on all pins with occasional resets
    rs = 1'b0; rc = 1'b1; rm = 1'b0; hs = 0; hc = 0; hm = 0;
    nrise = 0; nneg = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hs == 0) begin rs = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 9); end
      if (hc == 0) begin rc = 1'($urandom_range(0, 1)); hc = $urandom_range(1, 12); end
      if (hm == 0) begin rm = 1'($urandom_range(0, 1)); hm = $urandom_range(1, 7); end
      hs--; hc--; hm--;
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        step(rs, rc, rm);
        reset_n = 1'b1;
      end else begin
        step(rs, rc, rm);
      end
      nrise += int'(sclk_pos_edge);
      nneg += int'(sclk_pos_edge & sclk_neg_edge) + int'(cs_fall & cs_rise);
    end
    check_eq("rand_exclusive", nneg, 0);
    if (nrise == 0) check_eq("rand_activity", nrise, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_input_conditioner.md
SPI_INPUT_CONDITIONER -- requirements
Module: spi_input_conditioner

Interface
REQ-001 SHALL have parameter WAIT_TIME, default 3, the number of stable cycles required before a change is accepted.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 3, the width of each debounce counter.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk_pin  input  1  raw serial clock from master, asynchronous to clk.
REQ-006 SHALL have port cs_pin  input  1  raw chip select, active-low, asynchronous.
REQ-007 SHALL have port mosi_pin  input  1  raw master-out data, asynchronous.
REQ-008 SHALL have port sclk_pos_edge  output  1  one-cycle pulse on each accepted sclk rise; drives downstream fsm sclk_edge.
REQ-009 SHALL have port sclk_neg_edge  output  1  one-cycle pulse on each accepted sclk fall.
REQ-010 SHALL have port cs_cond  output  1  conditioned chip select level.
REQ-011 SHALL have port cs_fall  output  1  one-cycle pulse at transaction start.
REQ-012 SHALL have port cs_rise  output  1  one-cycle pulse at transaction end.
REQ-013 SHALL have port mosi_cond  output  1  conditioned data level.

Function
REQ-014 SHALL implement three identical channels (sclk, cs, mosi), each with a 2-FF synchronizer (s0, s1), a conditioned level register cond, and a COUNTER_WIDTH debounce counter.
REQ-015 Per channel, each clk: s0 <= pin, s1 <= s0.
REQ-016 Per channel, if s1 == cond: counter <= 0, cond unchanged.
REQ-017 Per channel, if s1 != cond and counter != WAIT_TIME: counter <= counter + 1.
REQ-018 Per channel, if s1 != cond and counter == WAIT_TIME: cond <= s1, counter <= 0, and the matching rise or fall pulse asserts for exactly that one following cycle.
REQ-019 Latency SHALL be fixed: pin change captured by s0 at edge k; cond and pulse visible after edge k+2+WAIT_TIME (edge k+5 at default).
REQ-020 A glitch whose s1 excursion lasts <= WAIT_TIME cycles SHALL produce no cond change and no pulse; the counter SHALL clear on return.
REQ-021 Pulses SHALL never exceed one cycle and SHALL never both assert in one cycle on the same channel.
REQ-022 Channels SHALL be independent; simultaneous accepted events on several channels SHALL produce their pulses in the same cycle.
REQ-023 sclk pulses SHALL be generated regardless of cs_cond; gating by chip select is the downstream fsm's job.
REQ-024 Because all channels share latency, mosi_cond at an sclk_pos_edge SHALL equal the mosi level held for >= WAIT_TIME+1 cycles before the sclk rise at the pins.
REQ-025 WAIT_TIME SHALL satisfy 1 <= WAIT_TIME <= 2^COUNTER_WIDTH-1; the counter SHALL never wrap.
REQ-026 Minimum sclk half-period for correct operation SHALL be WAIT_TIME+2 clk cycles; slower masters are unrestricted.

Reset
REQ-027 reset_n low SHALL immediately force: sclk s0/s1/cond = 0, cs s0/s1/cond = 1, mosi s0/s1/cond = 0, all counters 0, all pulses 0.
REQ-028 Reset mid-transaction SHALL abort without any pulse; after release, pins at idle (sclk 0, cs 1) SHALL produce no pulse.
REQ-029 After release with a pin at non-idle level, the normal REQ-018 acceptance SHALL apply (e.g. cs_pin held 0 yields cs_fall at edge 5 after release).

Verification
REQ-030 Reset, hold pins idle 20 cycles -> all pulses 0, cs_cond=1, sclk_pos_edge never asserts.
REQ-031 cs_pin 1->0 before edge 0 -> cs_cond falls and cs_fall is high for one cycle after edge 5; no other pulse.
REQ-032 sclk_pin high for 2 cycles then low -> no sclk_pos_edge, no sclk_neg_edge, counter back to 0.
REQ-033 cs_pin=0, 8 sclk periods of 8 high/8 low cycles, mosi = 0xA5 MSB-first changing on sclk fall -> exactly 8 sclk_pos_edge pulses, mosi_cond sampled at each = 1,0,1,0,0,1,0,1.
REQ-034 sclk_pin and cs_pin toggle in same cycle -> sclk_pos_edge and cs_rise assert in the same cycle.
REQ-035 reset_n pulsed low mid-byte with cs_pin=0 -> outputs reset instantly; cs_fall reasserts 5 cycles after release.
